// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - refill engine for the 8-set 4-way icache; macro ICACHE_CRIT_WORD_FIRST_EN
// enables critical-word-first burst ordering and crit_valid forwarding.
module icache_refill_ctrl #(
  parameter int WORDS_PER_BLOCK = 4,
  parameter int TAG_W           = 27,
  parameter int SET_W           = 3,
  parameter int TIMEOUT         = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               miss_req,
  input  logic [31:0]        miss_addr,
  input  logic [1:0]         lru_way,
  output logic               mem_req,
  output logic [31:0]        mem_addr,
  input  logic               mem_ready,
  input  logic [31:0]        mem_data,
  output logic               fill_we,
  output logic [SET_W-1:0]   fill_set,
  output logic [1:0]         fill_way,
  output logic [TAG_W-1:0]   fill_tag,
  output logic [127:0]       fill_data,
  output logic               fill_valid,
  output logic               fill_done,
  output logic               fill_err,
  output logic               busy,
  output logic               crit_valid
);

  localparam int              TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [1:0]      LAST_WORD = 2'(WORDS_PER_BLOCK - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [SET_W-1:0]   set_q, set_d;
  logic [1:0]         way_q, way_d;
  logic [1:0]         k_q, k_d;
  logic [1:0]         rcvd_q, rcvd_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [127:0]       buf_q, buf_d;
  logic [1:0]         start_word;
  logic               wait_expired;

`ifdef ICACHE_CRIT_WORD_FIRST_EN
  assign start_word = miss_addr[1:0];
`else
  logic unused_word_bits;
  assign start_word       = 2'd0;
  assign unused_word_bits = ^miss_addr[1:0];
`endif

  // Abort only when the final allowed cycle also passes without data.
  assign wait_expired = (state_q == S_WAIT) && !mem_ready && (tmo_q == TMO_MAX);

  always_ff @(negedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      set_q   <= '0;
      way_q   <= '0;
      k_q     <= '0;
      rcvd_q  <= '0;
      tmo_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      set_q   <= set_d;
      way_q   <= way_d;
      k_q     <= k_d;
      rcvd_q  <= rcvd_d;
      tmo_q   <= tmo_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    set_d   = set_q;
    way_d   = way_q;
    k_d     = k_q;
    rcvd_d  = rcvd_q;
    tmo_d   = tmo_q;
    buf_d   = buf_q;
    case (state_q)
      S_IDLE: begin
        if (miss_req) begin
          tag_d   = miss_addr[31:5];
          set_d   = miss_addr[4:2];
          way_d   = lru_way;
          k_d     = start_word;
          rcvd_d  = '0;
          tmo_d   = '0;
          buf_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_ready) begin
          buf_d[{k_q, 5'd0} +: 32] = mem_data;
          tmo_d = '0;
          if (rcvd_q == LAST_WORD) begin
            state_d = S_WRITE;
          end else begin
            rcvd_d  = rcvd_q + 2'd1;
            k_d     = k_q + 2'd1;
            state_d = S_REQ;
          end
        end else if (wait_expired) begin
          tmo_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    fill_we    = 1'b0;
    fill_valid = 1'b0;
    fill_done  = 1'b0;
    fill_err   = 1'b0;
    busy       = 1'b0;
    crit_valid = 1'b0;
    case (state_q)
      S_REQ: begin
        mem_req = 1'b1;
        busy    = 1'b1;
      end
      S_WAIT: begin
        if (wait_expired) begin
          fill_done = 1'b1;
          fill_err  = 1'b1;
        end else begin
          mem_req = 1'b1;
          busy    = 1'b1;
`ifdef ICACHE_CRIT_WORD_FIRST_EN
          crit_valid = mem_ready && (rcvd_q == 2'd0);
`endif
        end
      end
      S_WRITE: begin
        fill_we    = 1'b1;
        fill_valid = 1'b1;
        busy       = 1'b1;
      end
      S_DONE:  fill_done = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr  = mem_req ? {tag_q, set_q, k_q} : 32'd0;
  assign fill_set  = set_q;
  assign fill_way  = way_q;
  assign fill_tag  = tag_q;
  assign fill_data = buf_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - self-checking bench for icache_refill_ctrl with a queue-based refill model.
module tb_icache_refill_ctrl;

  localparam int TIMEOUT = 255;
`ifdef ICACHE_CRIT_WORD_FIRST_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif
  localparam logic [127:0] BLK_1000 = 128'h00001003_00001002_00001001_00001000;

  logic         clk = 1'b0;
  logic         reset, miss_req, mem_ready;
  logic [31:0]  miss_addr, mem_data, mem_addr;
  logic [1:0]   lru_way, fill_way;
  logic         mem_req, fill_we, fill_valid, fill_done, fill_err, busy, crit_valid;
  logic [2:0]   fill_set;
  logic [26:0]  fill_tag;
  logic [127:0] fill_data;

  always #5 clk = ~clk;

  icache_refill_ctrl dut (
    .clk(clk), .reset(reset), .miss_req(miss_req), .miss_addr(miss_addr), .lru_way(lru_way),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
    .fill_we(fill_we), .fill_set(fill_set), .fill_way(fill_way), .fill_tag(fill_tag),
    .fill_data(fill_data), .fill_valid(fill_valid), .fill_done(fill_done), .fill_err(fill_err),
    .busy(busy), .crit_valid(crit_valid)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: data arrives after `lat` idle WAIT cycles; word k returns 0x1000+k.
  int          lat = 0;
  bit          mem_en = 1'b1;
  int          rsp_cnt = 0;
  logic [31:0] rsp_addr = 32'd0;
  always @(posedge clk) begin
    if (mem_req && mem_en) begin
      if (rsp_cnt == 0 || mem_addr != rsp_addr) rsp_cnt = 1;
      else rsp_cnt++;
      rsp_addr = mem_addr;
    end else begin
      rsp_cnt = 0;
    end
    mem_ready = mem_en && mem_req && (rsp_cnt == lat + 2);
    mem_data  = mem_ready ? 32'h1000 + {30'd0, mem_addr[1:0]} : 32'hDEAD_BEEF;
  end

  // Reference model: a pending-word queue, a one-cycle request slot, and a two-cycle write/done tail.
  bit           m_act = 1'b0;
  int           m_order[$];
  bit           m_req, m_first, timed;
  int           m_stall, m_tail = 0;
  logic [26:0]  m_tag;
  logic [2:0]   m_set;
  logic [1:0]   m_way;
  logic [127:0] m_blk;
  logic         e_req, e_we, e_done, e_err, e_busy, e_crit;
  logic [31:0]  e_addr;

  int           we_cnt = 0, done_cnt = 0, err_cnt = 0, crit_cnt = 0;
  int           we_cyc = 0, done_cyc = 0, err_cyc = 0;
  logic [2:0]   we_set;
  logic [1:0]   we_way;
  logic [26:0]  we_tag;
  logic [127:0] we_data;
  int           word_log[$];

  always @(posedge clk) begin
    #2;
    e_req = 0; e_we = 0; e_done = 0; e_err = 0; e_busy = 0; e_crit = 0; e_addr = 32'd0; timed = 0;
    if (m_act && m_order.size() > 0) begin
      if (m_req) begin
        e_req = 1; e_busy = 1; e_addr = {m_tag, m_set, 2'(m_order[0])};
      end else if (m_stall == TIMEOUT && !mem_ready) begin
        timed = 1; e_done = 1; e_err = 1;
      end else begin
        e_req = 1; e_busy = 1; e_addr = {m_tag, m_set, 2'(m_order[0])};
        e_crit = CRIT && m_first && mem_ready;
      end
    end else if (m_act && m_tail == 2) begin
      e_we = 1; e_busy = 1;
    end else if (m_act && m_tail == 1) begin
      e_done = 1;
    end

    if (chk_en) begin
      chk("mem_req", mem_req, e_req);
      chk("mem_addr", mem_addr, e_addr);
      chk("fill_we", fill_we, e_we);
      chk("fill_valid", fill_valid, e_we);
      chk("fill_done", fill_done, e_done);
      chk("fill_err", fill_err, e_err);
      chk("busy", busy, e_busy);
      chk("crit_valid", crit_valid, e_crit);
      if (e_we) begin
        chk("fill_set", fill_set, m_set);
        chk("fill_way", fill_way, m_way);
        chk("fill_tag", fill_tag, m_tag);
        chk("fill_data", fill_data, m_blk);
      end
    end

    if (fill_we) begin
      we_cnt++; we_cyc = cyc; we_set = fill_set; we_way = fill_way; we_tag = fill_tag; we_data = fill_data;
    end
    if (fill_done) begin done_cnt++; done_cyc = cyc; end
    if (fill_err) begin err_cnt++; err_cyc = cyc; end
    if (crit_valid) crit_cnt++;
    if (mem_req && mem_ready) word_log.push_back(int'(mem_addr[1:0]));

    if (reset) begin
      m_act = 0; m_order.delete(); m_tail = 0;
    end else if (!m_act) begin
      if (miss_req) begin
        int sw;
        sw = CRIT ? int'(miss_addr[1:0]) : 0;
        m_act = 1; m_req = 1; m_first = 1; m_stall = 0; m_tail = 0; m_blk = '0;
        m_tag = miss_addr[31:5]; m_set = miss_addr[4:2]; m_way = lru_way;
        m_order.delete();
        for (int i = 0; i < 4; i++) m_order.push_back((sw + i) % 4);
      end
    end else if (m_order.size() > 0) begin
      if (m_req) begin
        m_req = 0;
      end else if (mem_ready) begin
        m_blk[m_order[0]*32 +: 32] = mem_data;
        void'(m_order.pop_front());
        m_first = 0; m_stall = 0;
        if (m_order.size() == 0) m_tail = 2;
        else m_req = 1;
      end else if (timed) begin
        m_act = 0;
      end else begin
        m_stall++;
      end
    end else if (m_tail == 2) begin
      m_tail = 1;
    end else begin
      m_tail = 0; m_act = 0;
    end
    cyc++;
  end

  int c0;

  task automatic do_miss(input logic [31:0] addr, input logic [1:0] way);
    @(posedge clk);
    miss_req = 1'b1; miss_addr = addr; lru_way = way; c0 = cyc;
    @(posedge clk);
    miss_req = 1'b0; miss_addr = 32'hFFFF_FFFF; lru_way = 2'd3;
  endtask

  task automatic wait_done(input int budget, input string name);
    int s, n;
    s = done_cnt; n = 0;
    while (done_cnt == s && n < budget) begin
      @(posedge clk); #3; n++;
    end
    chk(name, done_cnt != s, 1'b1);
  endtask

  task automatic chk_order(input string name, input logic [7:0] exp);
    logic [7:0] got;
    got = 8'hFF;
    if (word_log.size() == 4)
      got = {2'(word_log[0]), 2'(word_log[1]), 2'(word_log[2]), 2'(word_log[3])};
    chk(name, got, exp);
  endtask

  initial begin
    int s_we, s_done, s_err, s_crit;
    reset = 1'b1; miss_req = 1'b0; miss_addr = 32'd0; lru_way = 2'd0;
    mem_ready = 1'b0; mem_data = 32'd0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fill_done", fill_done, 1'b0);
    chk("rst_fill_data", fill_data, 128'd0);
    chk("rst_fill_tag", fill_tag, 27'd0);
    @(posedge clk);
    reset = 1'b0; chk_en = 1'b1;

    // Zero-wait refill
    word_log.delete(); s_err = err_cnt;
    do_miss(32'h0000_0A4B, 2'd2);
    wait_done(40, "t1_done_seen");
    chk("t1_we_latency", we_cyc - c0, 9);
    chk("t1_done_latency", done_cyc - c0, 10);
    chk("t1_set", we_set, 3'd2);
    chk("t1_way", we_way, 2'd2);
    chk("t1_tag", we_tag, 27'h52);
    chk("t1_data", we_data, BLK_1000);
    chk("t1_no_err", err_cnt - s_err, 0);

    // Three idle cycles before every word
    lat = 3; word_log.delete();
    do_miss(32'h0001_2340, 2'd1);
    wait_done(80, "t2_done_seen");
    chk("t2_we_latency", we_cyc - c0, 21);
    chk_order("t2_order", 8'b00_01_10_11);
    chk("t2_data", we_data, BLK_1000);
    lat = 0;

    // Timeout abort
    mem_en = 1'b0; s_we = we_cnt; s_err = err_cnt;
    do_miss(32'h0000_0100, 2'd3);
    wait_done(400, "t3_done_seen");
    chk("t3_done_latency", done_cyc - c0, 257);
    chk("t3_err_pulse", err_cnt - s_err, 1);
    chk("t3_err_with_done", err_cyc, done_cyc);
    chk("t3_no_fill_we", we_cnt - s_we, 0);
    mem_en = 1'b1;
    do_miss(32'h0000_0A4B, 2'd1);
    wait_done(40, "t3_refill_after");
    chk("t3_refill_way", we_way, 2'd1);
    chk("t3_refill_data", we_data, BLK_1000);

    // Miss while busy is dropped
    s_done = done_cnt; s_we = we_cnt;
    do_miss(32'h0000_0C80, 2'd0);
    @(posedge clk);
    @(posedge clk);
    miss_req = 1'b1; miss_addr = 32'h0000_7F00; lru_way = 2'd3;
    @(posedge clk);
    miss_req = 1'b0;
    wait_done(40, "t4_done_seen");
    repeat (20) @(posedge clk);
    #3;
    chk("t4_one_done", done_cnt - s_done, 1);
    chk("t4_one_we", we_cnt - s_we, 1);
    chk("t4_tag_first", we_tag, 27'h64);

    // Reset after two words
    s_done = done_cnt; s_we = we_cnt;
    do_miss(32'h0000_0A4B, 2'd2);
    repeat (4) @(posedge clk);
    reset = 1'b1;
    @(posedge clk);
    reset = 1'b0;
    #3;
    chk("t5_mem_req", mem_req, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_mem_addr", mem_addr, 32'd0);
    chk("t5_fill_data", fill_data, 128'd0);
    chk("t5_fill_tag", fill_tag, 27'd0);
    repeat (5) @(posedge clk);
    #3;
    chk("t5_no_done", done_cnt - s_done, 0);
    chk("t5_no_we", we_cnt - s_we, 0);
    word_log.delete();
    do_miss(32'h0000_0A48, 2'd2);
    wait_done(40, "t5_done_seen");
    chk_order("t5_order", 8'b00_01_10_11);
    chk("t5_data", we_data, BLK_1000);

`ifdef ICACHE_CRIT_WORD_FIRST_EN
    // Critical word first from word 2
    word_log.delete(); s_crit = crit_cnt;
    do_miss(32'h0000_0A4A, 2'd2);
    wait_done(40, "t6_done_seen");
    chk_order("t6_order", 8'b10_11_00_01);
    chk("t6_crit_once", crit_cnt - s_crit, 1);
    chk("t6_data", we_data, BLK_1000);
`else
    s_crit = crit_cnt;
    chk("t6_crit_tied", s_crit, 0);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
